// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 5-stage pipeline.
//
// Contents:
//   DATA_WIDTH, OPCODE_LENGTH, REG_ADDR : default datapath widths
//   ALU_AND/ADD/SUB/SLT/EQ              : ALU Operation encodings
//   fwd_sel_t                           : operand source chosen by forwarding
//   ex_ctrl_t                           : control bits carried into EX
package riscv_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_LENGTH = 4;
    localparam int REG_ADDR      = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
    } ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select logic for the EX stage operands.
//
// Ports:
//   rs1, rs2         in  : source register indices of the instruction in EX
//   exmem_reg_write  in  : EX/MEM stage will write a register
//   exmem_rd         in  : EX/MEM destination index
//   memwb_reg_write  in  : MEM/WB stage will write a register
//   memwb_rd         in  : MEM/WB destination index
//   fwd_a, fwd_b     out : operand source for A (rs1) and B (rs2)
module forward_unit
    import riscv_pkg::*;
#(
    parameter int REG_ADDR = riscv_pkg::REG_ADDR
) (
    input  logic [REG_ADDR-1:0] rs1,
    input  logic [REG_ADDR-1:0] rs2,
    input  logic                exmem_reg_write,
    input  logic [REG_ADDR-1:0] exmem_rd,
    input  logic                memwb_reg_write,
    input  logic [REG_ADDR-1:0] memwb_rd,
    output fwd_sel_t            fwd_a,
    output fwd_sel_t            fwd_b
);

    // x0 is hard-wired to zero, so a write "to" x0 must never be forwarded.
    logic exmem_live;
    logic memwb_live;

    assign exmem_live = exmem_reg_write && (exmem_rd != '0);
    assign memwb_live = memwb_reg_write && (memwb_rd != '0);

    // EX/MEM is checked first: it holds the younger result.
    always_comb begin
        fwd_a = FWD_REG;
        if (exmem_live && (exmem_rd == rs1)) begin
            fwd_a = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == rs1)) begin
            fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b = FWD_REG;
        if (exmem_live && (exmem_rd == rs2)) begin
            fwd_b = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == rs2)) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX-stage operand selection.
//
// Captures decoded operands and control, supports stall (hold) and flush
// (bubble), and forwards EX/MEM and MEM/WB results onto the ALU operands.
//
// Ports:
//   clk, reset (sync, active-low), stall, flush
//   id_*            in  : decoded instruction fields and control
//   exmem_*/memwb_* in  : later-stage writeback info used for forwarding
//   SrcA, SrcB      out : ALU operands
//   Operation       out : registered ALU op
//   ex_store_data   out : forwarded rs2 value for stores
//   ex_pc, ex_imm, ex_rd, ex_valid, ex_<ctrl> out : registered fields
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
    parameter int OPCODE_LENGTH = riscv_pkg::OPCODE_LENGTH,
    parameter int REG_ADDR      = riscv_pkg::REG_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rd1,
    input  logic [DATA_WIDTH-1:0]    id_rd2,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_reg_write,
    input  logic                     id_mem_to_reg,
    input  logic                     id_branch,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR-1:0]      exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR-1:0]      memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_valid,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_reg_write,
    output logic                     ex_mem_to_reg,
    output logic                     ex_branch
);

    // ---------------- pipeline registers ----------------
    logic [DATA_WIDTH-1:0]    pc_q,  pc_d;
    logic [DATA_WIDTH-1:0]    rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]    imm_q, imm_d;
    logic [REG_ADDR-1:0]      rs1_q, rs1_d;
    logic [REG_ADDR-1:0]      rs2_q, rs2_d;
    logic [REG_ADDR-1:0]      rd_q,  rd_d;
    logic [OPCODE_LENGTH-1:0] op_q,  op_d;
    logic                     alu_src_q, alu_src_d;
    logic                     valid_q, valid_d;
    ex_ctrl_t                 ctrl_q, ctrl_d;
    ex_ctrl_t                 id_ctrl;

    assign id_ctrl = '{mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       reg_write:  id_reg_write,
                       mem_to_reg: id_mem_to_reg,
                       branch:     id_branch};

    // Flush wins over stall. On a flush the data fields simply load (they are
    // don't-care behind a cleared valid); only the side-effecting control
    // bits are forced to zero so the bubble cannot write anything.
    always_comb begin
        pc_d      = pc_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        op_d      = op_q;
        alu_src_d = alu_src_q;
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        if (flush || !stall) begin
            pc_d      = id_pc;
            rd1_d     = id_rd1;
            rd2_d     = id_rd2;
            imm_d     = id_imm;
            rs1_d     = id_rs1;
            rs2_d     = id_rs2;
            rd_d      = id_rd;
            op_d      = id_alu_op;
            alu_src_d = id_alu_src;
            ctrl_d    = id_ctrl;
            valid_d   = 1'b1;
            if (flush) begin
                valid_d          = 1'b0;
                ctrl_d.mem_read  = 1'b0;
                ctrl_d.mem_write = 1'b0;
                ctrl_d.reg_write = 1'b0;
                ctrl_d.branch    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            alu_src_q <= 1'b0;
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            alu_src_q <= alu_src_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // ---------------- forwarding ----------------
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    forward_unit #(
        .REG_ADDR(REG_ADDR)
    ) u_forward_unit (
        .rs1             (rs1_q),
        .rs2             (rs2_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    // Evaluated every cycle, including while stalled, so a held instruction
    // picks up results that arrive in later stages during the stall.
    logic [DATA_WIDTH-1:0] fwd_a_val;
    logic [DATA_WIDTH-1:0] fwd_b_val;

    always_comb begin
        case (fwd_a)
            FWD_EXMEM: fwd_a_val = exmem_result;
            FWD_MEMWB: fwd_a_val = memwb_result;
            default:   fwd_a_val = rd1_q;
        endcase
    end

    always_comb begin
        case (fwd_b)
            FWD_EXMEM: fwd_b_val = exmem_result;
            FWD_MEMWB: fwd_b_val = memwb_result;
            default:   fwd_b_val = rd2_q;
        endcase
    end

    // ---------------- outputs ----------------
    assign SrcA          = fwd_a_val;
    assign SrcB          = alu_src_q ? imm_q : fwd_b_val;
    assign ex_store_data = fwd_b_val;
    assign Operation     = op_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_rd         = rd_q;
    assign ex_valid      = valid_q;
    assign ex_mem_read   = ctrl_q.mem_read  & valid_q;
    assign ex_mem_write  = ctrl_q.mem_write & valid_q;
    assign ex_reg_write  = ctrl_q.reg_write & valid_q;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch    & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage with an expected-value queue.
module tb_id_ex_operand_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, flush;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] src_a, src_b, ex_store_data, ex_pc, ex_imm;
    logic [3:0]  operation;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .SrcA(src_a), .SrcB(src_b), .Operation(operation), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] store;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        valid;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        br;
    } obs_t;

    typedef struct packed {
        logic [7:0] tag;
        logic       ctrl_only;   // data fields are don't-care (bubble)
        obs_t       o;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always @(negedge clk) begin
        exp_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{srca: src_a, srcb: src_b, store: ex_store_data, pc: ex_pc, imm: ex_imm,
                  op: operation, rd: ex_rd, valid: ex_valid, mr: ex_mem_read,
                  mw: ex_mem_write, rw: ex_reg_write, br: ex_branch};
            checks++;
            if (e.ctrl_only) begin
                if ({a.valid, a.mr, a.mw, a.rw, a.br} !== {e.o.valid, e.o.mr, e.o.mw, e.o.rw, e.o.br}) begin
                    failures++;
                    $display("FAIL step%0d ctrl: got v/mr/mw/rw/br=%b required=%b", e.tag,
                             {a.valid, a.mr, a.mw, a.rw, a.br}, {e.o.valid, e.o.mr, e.o.mw, e.o.rw, e.o.br});
                end
            end else if (a !== e.o) begin
                failures++;
                $display("FAIL step%0d outputs: got srca=%h srcb=%h st=%h pc=%h imm=%h op=%h rd=%0d v/mr/mw/rw/br=%b%b%b%b%b required srca=%h srcb=%h st=%h pc=%h imm=%h op=%h rd=%0d v/mr/mw/rw/br=%b%b%b%b%b",
                         e.tag, a.srca, a.srcb, a.store, a.pc, a.imm, a.op, a.rd, a.valid, a.mr, a.mw, a.rw, a.br,
                         e.o.srca, e.o.srcb, e.o.store, e.o.pc, e.o.imm, e.o.op, e.o.rd,
                         e.o.valid, e.o.mr, e.o.mw, e.o.rw, e.o.br);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [3:0] op, input logic src,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic br);
        id_pc = pc; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_op = op; id_alu_src = src;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
        id_mem_to_reg = m2r; id_branch = br;
    endtask

    task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [31:0] eres,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
        exmem_reg_write = ewe; exmem_rd = erd; exmem_result = eres;
        memwb_reg_write = wwe; memwb_rd = wrd; memwb_result = wres;
    endtask

    task automatic push_exp(input logic [7:0] tag, input logic ctrl_only,
                            input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] st,
                            input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] op,
                            input logic [4:0] rd, input logic v, input logic mr, input logic mw,
                            input logic rw, input logic br);
        exp_t e;
        e.tag = tag;
        e.ctrl_only = ctrl_only;
        e.o = '{srca: sa, srcb: sb, store: st, pc: pc, imm: imm, op: op, rd: rd,
                valid: v, mr: mr, mw: mw, rw: rw, br: br};
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd1, 5'd2, 5'd3,
               4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Two reset cycles with arbitrary ID inputs: everything zero.
        tick(); push_exp(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        tick(); push_exp(2, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);

        // Plain ADD, register operands.
        reset = 1'b1;
        set_id(32'h100, 32'd5, 32'd7, 32'h40, 5'd1, 5'd2, 5'd4, 4'b0010, 1'b0, 0, 0, 1, 0, 0);
        tick(); push_exp(3, 0, 32'd5, 32'd7, 32'd7, 32'h100, 32'h40, 4'b0010, 5'd4, 1, 0, 0, 1, 0);

        // Immediate on B; store data still rd2.
        set_id(32'h104, 32'd5, 32'd7, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd5, 4'b0000, 1'b1, 0, 0, 1, 0, 0);
        tick(); push_exp(4, 0, 32'd5, 32'hFFFF_FFFC, 32'd7, 32'h104, 32'hFFFF_FFFC, 4'b0000, 5'd5, 1, 0, 0, 1, 0);

        // rs1=3 matches both later stages: EX/MEM wins.
        set_id(32'h108, 32'h11, 32'h22, 32'h0, 5'd3, 5'd2, 5'd6, 4'b0100, 1'b0, 0, 0, 1, 0, 0);
        tick();
        set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        push_exp(5, 0, 32'h10, 32'h22, 32'h22, 32'h108, 32'h0, 4'b0100, 5'd6, 1, 0, 0, 1, 0);

        // Stall, drop EX/MEM match: held instruction now takes MEM/WB value.
        stall = 1'b1;
        set_id(32'h999, 32'h9, 32'h9, 32'h9, 5'd9, 5'd9, 5'd9, 4'b1000, 1'b1, 1, 1, 0, 0, 1);
        tick();
        set_fwd(1'b0, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        push_exp(6, 0, 32'h20, 32'h22, 32'h22, 32'h108, 32'h0, 4'b0100, 5'd6, 1, 0, 0, 1, 0);

        // rs2=0 with writes to x0 in both stages: no forwarding.
        stall = 1'b0;
        set_id(32'h10C, 32'h33, 32'h44, 32'h0, 5'd1, 5'd0, 5'd7, 4'b0101, 1'b0, 0, 0, 1, 0, 0);
        tick();
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        push_exp(7, 0, 32'h33, 32'h44, 32'h44, 32'h10C, 32'h0, 4'b0101, 5'd7, 1, 0, 0, 1, 0);

        // A from EX/MEM, B from MEM/WB; alu_src=1 so B only reaches store data.
        set_id(32'h110, 32'h1, 32'h2, 32'h55, 5'd8, 5'd9, 5'd8, 4'b1000, 1'b1, 0, 0, 1, 0, 0);
        tick();
        set_fwd(1'b1, 5'd8, 32'hE8, 1'b1, 5'd9, 32'hB9);
        push_exp(8, 0, 32'hE8, 32'h55, 32'hB9, 32'h110, 32'h55, 4'b1000, 5'd8, 1, 0, 0, 1, 0);

        // Memory instruction with all side-effect controls set.
        set_id(32'h114, 32'h100, 32'h200, 32'h8, 5'd10, 5'd11, 5'd12, 4'b0010, 1'b1, 1, 1, 1, 1, 0);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        push_exp(9, 0, 32'h100, 32'h8, 32'h200, 32'h114, 32'h8, 4'b0010, 5'd12, 1, 1, 1, 1, 0);

        // Three stalled cycles with different ID values: nothing moves.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h500 + 32'(i), 32'hA0 + 32'(i), 32'hB0, 32'hC0, 5'd20, 5'd21, 5'd22,
                   4'b0101, 1'b0, 0, 0, 0, 0, 1);
            tick();
            push_exp(8'(10 + i), 0, 32'h100, 32'h8, 32'h200, 32'h114, 32'h8, 4'b0010, 5'd12, 1, 1, 1, 1, 0);
        end

        // Stall and flush together: flush wins, bubble inserted.
        flush = 1'b1;
        set_id(32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'b0010, 1'b0, 1, 1, 1, 1, 1);
        tick(); push_exp(13, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);

        // Valid branch-type instruction.
        stall = 1'b0; flush = 1'b0;
        set_id(32'h200, 32'h3, 32'h4, 32'h0, 5'd13, 5'd14, 5'd15, 4'b0101, 1'b0, 0, 0, 1, 0, 1);
        tick(); push_exp(14, 0, 32'h3, 32'h4, 32'h4, 32'h200, 32'h0, 4'b0101, 5'd15, 1, 0, 0, 1, 1);

        // One reset cycle clears the valid instruction.
        reset = 1'b0;
        set_id(32'h204, 32'h7, 32'h8, 32'h9, 5'd1, 5'd2, 5'd3, 4'b0100, 1'b0, 1, 1, 1, 0, 1);
        tick(); push_exp(15, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);

        // Flush alone with a branch in ID: gated controls stay low.
        reset = 1'b1; flush = 1'b1;
        tick(); push_exp(16, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);

        // Normal load resumes after the bubble.
        flush = 1'b0;
        set_id(32'h208, 32'hAB, 32'hCD, 32'h10, 5'd4, 5'd5, 5'd6, 4'b0000, 1'b0, 1, 0, 1, 1, 0);
        tick(); push_exp(17, 0, 32'hAB, 32'hCD, 32'hCD, 32'h208, 32'h10, 4'b0000, 5'd6, 1, 1, 0, 1, 0);

        // Drain the queue with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and EX-stage operand selector for the 5-stage RV32 pipeline. It captures decode-stage operands and control, supports stall and flush, and applies EX/MEM and MEM/WB forwarding. It drives SrcA, SrcB and Operation directly into the ALU, and drives store data and registered control onward to the EX/MEM register.

Parameters:
DATA_WIDTH, 32, operand/immediate/PC width
OPCODE_LENGTH, 4, ALU Operation code width
REG_ADDR, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
stall  in  1  hold current contents (from hazard unit)
flush  in  1  load a bubble (branch taken / load-use)
id_pc  in  DATA_WIDTH  PC of decoded instruction
id_rd1  in  DATA_WIDTH  register file read data rs1
id_rd2  in  DATA_WIDTH  register file read data rs2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_ADDR  register indices
id_alu_op  in  OPCODE_LENGTH  ALU Operation code
id_alu_src  in  1  1: SrcB = immediate
id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1  control
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_ADDR  EX/MEM destination
exmem_result  in  DATA_WIDTH  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_ADDR  MEM/WB destination
memwb_result  in  DATA_WIDTH  MEM/WB writeback value
SrcA, SrcB  out  DATA_WIDTH  ALU operands (combinational after register)
Operation  out  OPCODE_LENGTH  registered ALU op
ex_store_data  out  DATA_WIDTH  forwarded rs2 for stores
ex_pc, ex_imm  out  DATA_WIDTH  registered PC, immediate
ex_rd  out  REG_ADDR  registered destination
ex_valid  out  1  stage holds a real instruction
ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1  gated control

Behaviour:
- All state updates on rising clk. Priority: reset low > flush > stall > load.
- reset low: every register cleared to 0 (ex_valid=0, Operation=0, all control 0, data 0). SrcA/SrcB then reflect zeroed operands, or forwarded values if a forwarding match on x0 were possible, which it is not.
- load (no stall/flush): all id_* captured; ex_valid<=1. Latency is one cycle from ID inputs to registered outputs.
- stall: all registers hold. Forwarding muxes still re-evaluate every cycle on current exmem/memwb inputs.
- flush: ex_valid<=0; mem_read, mem_write, reg_write and branch cleared; data fields may load but are don't-care. flush and stall together: flush wins.
- Outputs ex_mem_read/ex_mem_write/ex_reg_write/ex_branch are ANDed with ex_valid.
- Forwarding for A (uses registered rs1) and B (uses registered rs2), evaluated independently:
  - select exmem_result if exmem_reg_write && exmem_rd!=0 && exmem_rd==rs
  - else select memwb_result if memwb_reg_write && memwb_rd!=0 && memwb_rd==rs
  - else use the registered rd1/rd2
  - EX/MEM has priority when both match.
- SrcA = fwdA. SrcB = alu_src ? imm : fwdB. ex_store_data = fwdB always.
- No arithmetic in this block; widths pass through unchanged.

Decomposition:
- Shared package riscv_pkg: DATA_WIDTH/REG_ADDR constants; ALU op codes AND=0000, ADD=0010, SUB=0100, SLT=0101, EQ=1000; enum fwd_sel_t {FWD_REG, FWD_EXMEM, FWD_MEMWB}; packed struct ex_ctrl_t for control bits.
- Sub-module forward_unit: combinational, computes fwd_sel_t for A and B. Instantiated once.

Test Plan:
- reset=0 for 2 cycles with arbitrary ID inputs -> all outputs 0, ex_valid=0; release, load rd1=5, rd2=7, alu_op=0010, alu_src=0 -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- alu_src=1, imm=0xFFFFFFFC -> SrcB=0xFFFFFFFC; ex_store_data still equals rd2.
- rs1=3; exmem_reg_write=1, exmem_rd=3, exmem_result=0x10; memwb_rd=3, memwb_result=0x20 -> SrcA=0x10. Drop the EX/MEM match -> SrcA=0x20.
- rs2=0 with exmem_rd=0, exmem_reg_write=1, result=0xAA -> SrcB=rd2, no forwarding.
- Load instruction with reg_write=1, mem_write=1, then stall=1 for 3 cycles with new ID values -> outputs unchanged. Next, stall=1 and flush=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Loaded valid instruction, then reset=0 for one cycle -> ex_valid=0 and Operation=0 on the following edge.
